// File: rtl/rv32i_mem_arbiter.sv
// Two-master (instruction fetch / data LSU) arbiter onto one pipelined memory port.
// Responses are steered back in acceptance order via a small requester-ID FIFO.
module rv32i_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        resp_err_o,
    output logic [2:0]  outstanding_o
);

    localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e                 state_q, state_d;
    logic                       last_data_q, last_data_d;
    logic                       lock_data_q, lock_data_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic sel_data;
    logic sel_req;
    logic has_room;
    logic accept;
    logic fifo_empty;
    logic pop;
    logic head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // sel_data: 1 selects the data port, 0 the instruction port
    always_comb begin
        sel_data = 1'b0;
        if (state_q == ARB_LOCKED) begin
            sel_data = lock_data_q;
        end else if (instr_req_i && !data_req_i) begin
            sel_data = 1'b0;
        end else if (data_req_i && !instr_req_i) begin
            sel_data = 1'b1;
        end else begin
            sel_data = ~last_data_q;
        end
    end

    assign sel_req  = sel_data ? data_req_i : instr_req_i;
    assign has_room = (cnt_q < MAX_CNT);
    // Gated by rst_ni so nothing is presented downstream while reset is held
    assign mem_req_o = rst_ni & sel_req & has_room;
    assign accept    = mem_req_o & mem_gnt_i;

    assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = sel_data & data_we_i;
    assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;

    assign instr_gnt_o = accept & ~sel_data;
    assign data_gnt_o  = accept &  sel_data;

    assign fifo_empty     = (cnt_q == '0);
    assign pop            = mem_rvalid_i & ~fifo_empty;
    assign head_data      = id_q[rd_ptr_q];
    assign instr_rvalid_o = pop & ~head_data;
    assign data_rvalid_o  = pop &  head_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign resp_err_o    = err_q;
    assign outstanding_o = cnt_q;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        lock_data_d = lock_data_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    last_data_d = sel_data;
                end else if (mem_req_o) begin
                    state_d     = ARB_LOCKED;
                    lock_data_d = sel_data;
                end
            end
            ARB_LOCKED: begin
                if (accept) begin
                    state_d     = ARB_IDLE;
                    last_data_d = sel_data;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | (mem_rvalid_i & fifo_empty);
        if (accept) begin
            id_d[wr_ptr_q] = sel_data;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            last_data_q <= 1'b0;
            lock_data_q <= 1'b0;
            id_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            lock_data_q <= lock_data_d;
            id_q        <= id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rv32i_mem_arbiter;

    localparam int unsigned MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        resp_err_o;
    logic [2:0]  outstanding_o;

    rv32i_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .resp_err_o(resp_err_o), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ir, dr, gnt, rv;
        logic [31:0] rd;
        logic        e_req, e_ig, e_dg;
        logic [31:0] e_addr;
        logic        e_irv, e_drv;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    // reference model state
    int q[$];
    int last_g;
    int pend;
    bit m_err;

    function automatic vec_t mk(logic ir, logic dr, logic gnt, logic rv, logic [31:0] rd,
                                logic e_req, logic e_ig, logic e_dg, logic [31:0] e_addr,
                                logic e_irv, logic e_drv, logic [2:0] e_out, logic e_err);
        vec_t v;
        v.ir = ir; v.dr = dr; v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_ig = e_ig; v.e_dg = e_dg; v.e_addr = e_addr;
        v.e_irv = e_irv; v.e_drv = e_drv; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic ir, input logic dr, input logic gnt,
                          input logic rv, input logic [31:0] rd);
        instr_req_i  = ir;
        instr_addr_i = 32'h100;
        data_req_i   = dr;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h200;
        data_wdata_i = 32'h0;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
        rst_ni = 1'b0;
        #2;
        chk("rst mem_req", mem_req_o, 1'b0);
        chk("rst outst", outstanding_o, 3'd0);
        chk("rst err", resp_err_o, 1'b0);
        chk("rst rvalids", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_ni = 1'b1;
    endtask

    initial begin
        // ir dr gnt rv rd | req ig dg addr irv drv out err
        tbl.push_back(mk(0,0,0,0,32'h00, 0,0,0,32'h000, 0,0,3'd0,0));
        tbl.push_back(mk(1,1,1,0,32'h00, 1,0,1,32'h200, 0,0,3'd0,0));
        tbl.push_back(mk(1,1,1,1,32'h11, 1,1,0,32'h100, 0,1,3'd1,0));
        tbl.push_back(mk(1,1,1,1,32'h22, 1,0,1,32'h200, 1,0,3'd1,0));
        tbl.push_back(mk(1,1,1,1,32'h33, 1,1,0,32'h100, 0,1,3'd1,0));
        tbl.push_back(mk(0,0,0,1,32'h44, 0,0,0,32'h000, 1,0,3'd1,0));
        tbl.push_back(mk(0,0,0,1,32'h55, 0,0,0,32'h000, 0,0,3'd0,0));
        tbl.push_back(mk(1,0,0,0,32'h00, 1,0,0,32'h100, 0,0,3'd0,1));
        tbl.push_back(mk(1,1,0,0,32'h00, 1,0,0,32'h100, 0,0,3'd0,1));
        tbl.push_back(mk(1,1,0,0,32'h00, 1,0,0,32'h100, 0,0,3'd0,1));
        tbl.push_back(mk(1,1,1,0,32'h00, 1,1,0,32'h100, 0,0,3'd0,1));
        tbl.push_back(mk(1,1,1,0,32'h00, 1,0,1,32'h200, 0,0,3'd1,1));
        tbl.push_back(mk(1,1,1,0,32'h00, 0,0,0,32'h000, 0,0,3'd2,1));
        tbl.push_back(mk(1,1,1,1,32'h66, 0,0,0,32'h000, 1,0,3'd2,1));
        tbl.push_back(mk(1,1,1,0,32'h00, 1,1,0,32'h100, 0,0,3'd1,1));
        tbl.push_back(mk(1,1,1,1,32'h77, 0,0,0,32'h000, 0,1,3'd2,1));
        tbl.push_back(mk(0,0,0,1,32'h88, 0,0,0,32'h000, 1,0,3'd1,1));
        tbl.push_back(mk(0,0,0,0,32'h00, 0,0,0,32'h000, 0,0,3'd0,1));

        #1;
        do_reset();

        foreach (tbl[i]) begin
            set_in(tbl[i].ir, tbl[i].dr, tbl[i].gnt, tbl[i].rv, tbl[i].rd);
            #2;
            chk($sformatf("vec%0d req", i), mem_req_o, tbl[i].e_req);
            chk($sformatf("vec%0d igt", i), instr_gnt_o, tbl[i].e_ig);
            chk($sformatf("vec%0d dgt", i), data_gnt_o, tbl[i].e_dg);
            if (tbl[i].e_req) chk($sformatf("vec%0d addr", i), mem_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d irv", i), instr_rvalid_o, tbl[i].e_irv);
            chk($sformatf("vec%0d drv", i), data_rvalid_o, tbl[i].e_drv);
            chk($sformatf("vec%0d outst", i), outstanding_o, tbl[i].e_out);
            chk($sformatf("vec%0d err", i), resp_err_o, tbl[i].e_err);
            if (tbl[i].rv) begin
                chk($sformatf("vec%0d irdata", i), instr_rdata_o, tbl[i].rd);
                chk($sformatf("vec%0d drdata", i), data_rdata_o, tbl[i].rd);
            end
            step();
        end

        // in-order response routing: instr, data, instr
        set_in(1, 0, 1, 0, 0); #2;
        chk("ord A igt", instr_gnt_o, 1'b1);
        step();
        set_in(0, 1, 1, 0, 0); #2;
        chk("ord B dgt", data_gnt_o, 1'b1);
        step();
        set_in(0, 0, 0, 1, 32'h11); #2;
        chk("ord C outst", outstanding_o, 3'd2);
        chk("ord C rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
        chk("ord C rdata", instr_rdata_o, 32'h11);
        step();
        set_in(1, 0, 1, 1, 32'h22); #2;
        chk("ord D rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);
        chk("ord D rdata", data_rdata_o, 32'h22);
        chk("ord D igt", instr_gnt_o, 1'b1);
        step();
        set_in(0, 0, 0, 1, 32'h33); #2;
        chk("ord E outst", outstanding_o, 3'd1);
        chk("ord E rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
        chk("ord E rdata", instr_rdata_o, 32'h33);
        step();
        set_in(0, 0, 0, 0, 0); #2;
        chk("ord F outst", outstanding_o, 3'd0);
        step();

        // unexpected response: sticky until reset
        do_reset();
        set_in(0, 0, 0, 1, 32'hAB); #2;
        chk("unexp rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        chk("unexp err0", resp_err_o, 1'b0);
        step();
        set_in(0, 0, 0, 0, 0); #2;
        chk("unexp err1", resp_err_o, 1'b1);
        chk("unexp outst", outstanding_o, 3'd0);
        repeat (3) step();
        chk("unexp sticky", resp_err_o, 1'b1);
        rst_ni = 1'b0; #1;
        chk("unexp clr", resp_err_o, 1'b0);
        step();
        rst_ni = 1'b1;

        // reset mid-transaction discards pending IDs
        set_in(1, 0, 1, 0, 0); step();
        set_in(0, 1, 1, 0, 0); step();
        set_in(1, 0, 0, 0, 0); #2;
        chk("midrst outst2", outstanding_o, 3'd2);
        rst_ni = 1'b0; #1;
        chk("midrst outst0", outstanding_o, 3'd0);
        chk("midrst req", mem_req_o, 1'b0);
        step();
        rst_ni = 1'b1;
        set_in(0, 0, 0, 1, 32'h5); #2;
        chk("midrst stale rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        step();
        set_in(0, 1, 1, 0, 0);
        data_we_i = 1'b1; data_be_i = 4'b0011;
        data_addr_i = 32'h300; data_wdata_i = 32'hCAFE_0001;
        #2;
        chk("store err", resp_err_o, 1'b1);
        chk("store dgt", data_gnt_o, 1'b1);
        chk("store we", mem_we_o, 1'b1);
        chk("store be", mem_be_o, 4'b0011);
        chk("store addr", mem_addr_o, 32'h300);
        chk("store wdata", mem_wdata_o, 32'hCAFE_0001);
        step();

        // randomized traffic against the reference model
        do_reset();
        q.delete(); last_g = 0; pend = -1; m_err = 0;
        for (int c = 0; c < 400; c++) begin
            int  own;
            bit  e_req, unexp;
            logic ir, dr, gnt, rv;
            ir  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            gnt = ($urandom_range(0, 3) != 0);
            rv  = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            instr_req_i  = ir;
            instr_addr_i = $urandom;
            data_req_i   = dr;
            data_we_i    = 1'($urandom_range(0, 1));
            data_be_i    = 4'($urandom_range(0, 15));
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
            mem_gnt_i    = gnt;
            mem_rvalid_i = rv;
            mem_rdata_i  = $urandom;

            own = -1;
            if (pend >= 0)      own = pend;
            else if (ir && dr)  own = 1 - last_g;
            else if (ir)        own = 0;
            else if (dr)        own = 1;
            e_req = (own >= 0) && ((own == 1) ? dr : ir) && (q.size() < MAXO);
            unexp = rv && (q.size() == 0);

            #2;
            chk($sformatf("rnd%0d req", c), mem_req_o, e_req);
            chk($sformatf("rnd%0d igt", c), instr_gnt_o, e_req && gnt && own == 0);
            chk($sformatf("rnd%0d dgt", c), data_gnt_o, e_req && gnt && own == 1);
            chk($sformatf("rnd%0d irv", c), instr_rvalid_o, rv && q.size() > 0 && q[0] == 0);
            chk($sformatf("rnd%0d drv", c), data_rvalid_o, rv && q.size() > 0 && q[0] == 1);
            chk($sformatf("rnd%0d outst", c), outstanding_o, q.size());
            chk($sformatf("rnd%0d err", c), resp_err_o, m_err);
            chk($sformatf("rnd%0d rdata", c), {instr_rdata_o ^ mem_rdata_i, data_rdata_o ^ mem_rdata_i}, 0);
            if (e_req) begin
                chk($sformatf("rnd%0d addr", c), mem_addr_o, own ? data_addr_i : instr_addr_i);
                chk($sformatf("rnd%0d we", c), mem_we_o, own ? data_we_i : 1'b0);
                chk($sformatf("rnd%0d be", c), mem_be_o, own ? data_be_i : 4'hF);
                chk($sformatf("rnd%0d wdata", c), mem_wdata_o, own ? data_wdata_i : 32'h0);
            end

            if (unexp) m_err = 1;
            if (rv && q.size() > 0) void'(q.pop_front());
            if (e_req && gnt) begin
                q.push_back(own);
                last_g = own;
                pend   = -1;
            end else if (e_req) begin
                pend = own;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
